// File: rtl/fetch_buffer.sv
// Decoupling queue between fetch and decode: stores whole fetch packets and
// issues one instruction (or one fault marker) per cycle in program order.
module fetch_buffer #(
  parameter int DEPTH   = 4,
  parameter int FETCH_W = 2,
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ADDR_W-1:0]          in_pc_i,
  input  logic [FETCH_W-1:0]         in_mask_i,
  input  logic [FETCH_W*INSTR_W-1:0] in_data_i,
  input  logic                       in_fault_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ADDR_W-1:0]          out_pc_o,
  output logic [INSTR_W-1:0]         out_instr_o,
  output logic                       out_fault_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  logic [ADDR_W-1:0]               pc_q   [DEPTH];
  logic [FETCH_W-1:0][INSTR_W-1:0] data_q [DEPTH];
  logic [FETCH_W-1:0]              mask_q [DEPTH];
  logic [DEPTH-1:0]                fault_q;
  logic [PTR_W-1:0]                rd_q, wr_q;
  logic [CNT_W-1:0]                count_q;

  logic [FETCH_W-1:0] head_mask, rem_next;
  logic [SLOT_W-1:0]  slot;
  logic               head_fault, push, pop, retire;

  assign head_mask  = mask_q[rd_q];
  assign head_fault = fault_q[rd_q];

  // The head entry's mask is cleared in place as slots issue, so it doubles
  // as the remaining mask; a fresh entry at the head starts with its full mask.
  always_comb begin
    slot = '0;
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      if (head_mask[i]) slot = SLOT_W'(i);
    end
  end

  assign rem_next = head_mask & ~(FETCH_W'(1) << slot);

  assign in_ready_o  = (count_q < CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign occupancy_o = count_q;

  // Empty packets without a fault carry nothing to issue, so they are not stored.
  assign push   = in_valid_i & in_ready_o & ~flush_i & ((|in_mask_i) | in_fault_i);
  assign pop    = out_valid_o & out_ready_i & ~flush_i;
  assign retire = pop & (head_fault | ~(|rem_next));

  assign out_pc_o    = out_valid_o ? (pc_q[rd_q] + ADDR_W'({slot, 2'b00})) : '0;
  assign out_instr_o = (out_valid_o & ~head_fault) ? data_q[rd_q][slot] : '0;
  assign out_fault_o = out_valid_o & head_fault;

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_q[wr_q]   <= in_pc_i;
      data_q[wr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fault_q <= '0;
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
    end else if (flush_i) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      if (push) begin
        mask_q[wr_q]  <= in_mask_i;
        fault_q[wr_q] <= in_fault_i;
        wr_q          <= wr_q + PTR_W'(1);
      end
      // A push never targets the head slot while entries are queued, so the
      // in-place mask update cannot collide with the write above.
      if (pop) begin
        if (retire) rd_q <= rd_q + PTR_W'(1);
        else        mask_q[rd_q] <= rem_next;
      end
      case ({push, retire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a randomized run,
// all compared against a queue-of-expected-instructions reference model.
module tb_fetch_buffer;

  localparam int DEPTH   = 4;
  localparam int FETCH_W = 2;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic                       flush_i = 1'b0;
  logic                       in_valid_i = 1'b0;
  logic                       in_ready_o;
  logic [ADDR_W-1:0]          in_pc_i = '0;
  logic [FETCH_W-1:0]         in_mask_i = '0;
  logic [FETCH_W*INSTR_W-1:0] in_data_i = '0;
  logic                       in_fault_i = 1'b0;
  logic                       out_valid_o;
  logic                       out_ready_i = 1'b0;
  logic [ADDR_W-1:0]          out_pc_o;
  logic [INSTR_W-1:0]         out_instr_o;
  logic                       out_fault_o;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;

  fetch_buffer #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
    .in_mask_i(in_mask_i), .in_data_i(in_data_i), .in_fault_i(in_fault_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_instr_o(out_instr_o), .out_fault_o(out_fault_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic        last;
  } item_t;

  // Reference model: every stored packet is expanded into the items decode should see.
  item_t q[$];
  int    pkt_cnt = 0;
  int    checks = 0;
  int    failures = 0;
  bit    last_push = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expand(input logic [31:0] pc, input logic [1:0] mask,
                        input logic [63:0] data, input logic fault);
    item_t it;
    int lo, hi;
    lo = 0; hi = -1;
    for (int i = FETCH_W - 1; i >= 0; i--) if (mask[i]) lo = i;
    for (int i = 0; i < FETCH_W; i++) if (mask[i]) hi = i;
    if (fault) begin
      it.pc = pc + 32'(4 * lo); it.instr = '0; it.fault = 1'b1; it.last = 1'b1;
      q.push_back(it);
    end else begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (mask[i]) begin
          it.pc = pc + 32'(4 * i); it.instr = data[i*32 +: 32];
          it.fault = 1'b0; it.last = (i == hi);
          q.push_back(it);
        end
      end
    end
  endtask

  task automatic checkOutput();
    item_t e;
    if (q.size() != 0) e = q[0];
    else begin e.pc = '0; e.instr = '0; e.fault = 1'b0; e.last = 1'b0; end
    chk("out_valid", out_valid_o, q.size() != 0);
    chk("in_ready", in_ready_o, pkt_cnt < DEPTH);
    chk("occupancy", occupancy_o, pkt_cnt);
    chk("out_pc", out_pc_o, e.pc);
    chk("out_instr", out_instr_o, e.instr);
    chk("out_fault", out_fault_o, e.fault);
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [1:0] mask,
                               input logic [63:0] data, input logic fault,
                               input logic ready, input logic flush);
    in_valid_i = valid; in_pc_i = pc; in_mask_i = mask; in_data_i = data;
    in_fault_i = fault; out_ready_i = ready; flush_i = flush;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit push, pop, fl;
    logic [31:0] pc; logic [1:0] mask; logic [63:0] data; logic fault;
    @(negedge clk_i);
    checkOutput();
    fl = flush_i; pc = in_pc_i; mask = in_mask_i; data = in_data_i; fault = in_fault_i;
    last_push = in_valid_i && (pkt_cnt < DEPTH) && !fl;
    push = last_push && (mask != 0 || fault);
    pop  = (q.size() != 0) && out_ready_i && !fl;
    @(posedge clk_i);
    if (fl) begin
      q.delete(); pkt_cnt = 0;
    end else begin
      if (pop) begin
        if (q[0].last) pkt_cnt--;
        void'(q.pop_front());
      end
      if (push) begin
        expand(pc, mask, data, fault);
        pkt_cnt++;
      end
    end
    #1;
  endtask

  logic [31:0] rpc;
  logic [1:0]  rmask;
  logic [63:0] rdata;
  logic        rfault;

  initial begin
    int sent, cyc, n;
    bit have;
    $display("[TB] start");
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_valid", out_valid_o, 1'b0);
    chk("reset_ready", in_ready_o, 1'b1);
    chk("reset_occ", occupancy_o, 0);
    chk("reset_fault", out_fault_o, 1'b0);
    rst_ni = 1'b1;

    // Two-slot packet issues in order, one per cycle, one cycle after the push
    applyStimulus(1, 32'h1000, 2'b11, {32'hBBBB0002, 32'hAAAA0001}, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    chk("t1_pc0", out_pc_o, 32'h1000);
    chk("t1_instr0", out_instr_o, 32'hAAAA0001);
    step();
    chk("t1_pc1", out_pc_o, 32'h1004);
    chk("t1_instr1", out_instr_o, 32'hBBBB0002);
    step();
    chk("t1_empty", out_valid_o, 1'b0);

    // Sparse mask and an empty packet that must be dropped
    applyStimulus(1, 32'h2000, 2'b10, {32'h22220002, 32'h22220001}, 0, 1, 0);
    step();
    applyStimulus(1, 32'h2008, 2'b00, {32'h33330002, 32'h33330001}, 0, 1, 0);
    chk("t2_pc", out_pc_o, 32'h2004);
    chk("t2_instr", out_instr_o, 32'h22220002);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    chk("t2_dropped", out_valid_o, 1'b0);
    step();

    // Fill to capacity with decode stalled, then drain
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h4000 + 32'(8 * k), 2'b11, {32'h44440000 + 32'(2 * k + 1), 32'h44440000 + 32'(2 * k)}, 0, 0, 0);
      step();
    end
    chk("t3_full_ready", in_ready_o, 1'b0);
    chk("t3_full_occ", occupancy_o, 4);
    applyStimulus(1, 32'h4020, 2'b11, {32'h44440009, 32'h44440008}, 0, 1, 0);
    n = 0;
    do begin step(); n++; end while (!last_push && n < 20);
    chk("t3_fifth_taken", last_push, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (12) step();

    // Fault packet yields a single marker, then the following packet issues normally
    applyStimulus(1, 32'h3000, 2'b11, {32'h55550002, 32'h55550001}, 1, 0, 0);
    step();
    applyStimulus(1, 32'h3008, 2'b11, {32'h66660002, 32'h66660001}, 0, 0, 0);
    step();
    chk("t4_fault", out_fault_o, 1'b1);
    chk("t4_pc", out_pc_o, 32'h3000);
    chk("t4_instr", out_instr_o, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();

    // Flush with a packet offered in the same cycle
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h5000 + 32'(8 * k), 2'b11, {32'h77770000 + 32'(2 * k + 1), 32'h77770000 + 32'(2 * k)}, 0, 0, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    step();
    applyStimulus(1, 32'h6000, 2'b11, {32'h88880002, 32'h88880001}, 0, 1, 1);
    step();
    chk("t5_valid", out_valid_o, 1'b0);
    chk("t5_occ", occupancy_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (3) step();

    // Randomized traffic including a packet at the top of the address space
    sent = 0; cyc = 0; have = 0;
    while (sent < 200 && cyc < 5000) begin
      if (!have) begin
        if (sent == 60) begin
          rpc = 32'hFFFFFFF8; rmask = 2'b11; rfault = 1'b0;
        end else begin
          rpc = $urandom & 32'hFFFFFFF8;
          rmask = 2'($urandom_range(0, 3));
          rfault = ($urandom_range(0, 7) == 0);
        end
        rdata = {$urandom, $urandom};
        have = 1;
      end
      applyStimulus($urandom_range(0, 9) < 7, rpc, rmask, rdata, rfault,
                    $urandom_range(0, 9) < 6, 0);
      step();
      cyc++;
      if (last_push) begin sent++; have = 0; end
    end
    chk("rand_sent", sent, 200);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    n = 0;
    while (q.size() != 0 && n < 100) begin step(); n++; end
    chk("rand_drained", out_valid_o, 1'b0);

    // Asynchronous reset while holding data
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 32'h7000 + 32'(8 * k), 2'b01, {32'h0, 32'h99990000 + 32'(k)}, 0, 0, 0);
      step();
    end
    chk("async_pre_occ", occupancy_o, 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_valid", out_valid_o, 1'b0);
    chk("async_occ", occupancy_o, 0);
    chk("async_ready", in_ready_o, 1'b1);
    q.delete(); pkt_cnt = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
